morse_stream_encoder: RTL

//  Parametrised successor to the 3-bit, 8-letter Morse blinker. It encodes the full A-Z alphabet, plus

---
 rtl/morse_stream_encoder_if.sv | 21 ++
 rtl/morse_stream_encoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/morse_stream_encoder_if.sv
// Character-in / light-out bundle for morse_stream_encoder.
// The master drives codes and abort; the encoder (slave) returns handshake and status.
interface morse_stream_encoder_if;
    logic [5:0] code_in;
    logic       code_valid;
    logic       code_ready;
    logic       abort;
    logic       light;
    logic       busy;
    logic       err;

    modport master (
        output code_in, code_valid, abort,
        input  code_ready, light, busy, err
    );

    modport slave (
        input  code_in, code_valid, abort,
        output code_ready, light, busy, err
    );
endinterface

// File: rtl/morse_stream_encoder.sv
// Streaming Morse encoder: one character per handshake, mark/space/letter-gap timing on one light.
// Digits 0-9 (codes 26-35) are decoded only when MORSE_DIGITS_EN is defined.
module morse_stream_encoder #(
    parameter int unsigned UNIT_CYCLES = 25000000,
    parameter int unsigned DASH_UNITS  = 3,
    parameter int unsigned GAP_UNITS   = 3,
    parameter int unsigned TIMER_W     = 27
) (
    input logic                    clk,
    input logic                    resetn,
    morse_stream_encoder_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StMark, StSpace, StLgap} state_e;

    localparam logic [TIMER_W-1:0] DotLast  = TIMER_W'(UNIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DashLast = TIMER_W'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GapLast  = TIMER_W'(GAP_UNITS * UNIT_CYCLES - 1);

    // Returns {supported, length[2:0], pattern[4:0]}; pattern is LSB-first, 1 = dash.
    function automatic logic [8:0] decode(input logic [5:0] code);
        logic [8:0] dec;
        dec = '0;
        case (code)
            6'd0:  dec = {1'b1, 3'd2, 5'd2};   // A .-
            6'd1:  dec = {1'b1, 3'd4, 5'd1};   // B -...
            6'd2:  dec = {1'b1, 3'd4, 5'd5};   // C -.-.
            6'd3:  dec = {1'b1, 3'd3, 5'd1};   // D -..
            6'd4:  dec = {1'b1, 3'd1, 5'd0};   // E .
            6'd5:  dec = {1'b1, 3'd4, 5'd4};   // F ..-.
            6'd6:  dec = {1'b1, 3'd3, 5'd3};   // G --.
            6'd7:  dec = {1'b1, 3'd4, 5'd0};   // H ....
            6'd8:  dec = {1'b1, 3'd2, 5'd0};   // I ..
            6'd9:  dec = {1'b1, 3'd4, 5'd14};  // J .---
            6'd10: dec = {1'b1, 3'd3, 5'd5};   // K -.-
            6'd11: dec = {1'b1, 3'd4, 5'd2};   // L .-..
            6'd12: dec = {1'b1, 3'd2, 5'd3};   // M --
            6'd13: dec = {1'b1, 3'd2, 5'd1};   // N -.
            6'd14: dec = {1'b1, 3'd3, 5'd7};   // O ---
            6'd15: dec = {1'b1, 3'd4, 5'd6};   // P .--.
            6'd16: dec = {1'b1, 3'd4, 5'd11};  // Q --.-
            6'd17: dec = {1'b1, 3'd3, 5'd2};   // R .-.
            6'd18: dec = {1'b1, 3'd3, 5'd0};   // S ...
            6'd19: dec = {1'b1, 3'd1, 5'd1};   // T -
            6'd20: dec = {1'b1, 3'd3, 5'd4};   // U ..-
            6'd21: dec = {1'b1, 3'd4, 5'd8};   // V ...-
            6'd22: dec = {1'b1, 3'd3, 5'd6};   // W .--
            6'd23: dec = {1'b1, 3'd4, 5'd9};   // X -..-
            6'd24: dec = {1'b1, 3'd4, 5'd13};  // Y -.--
            6'd25: dec = {1'b1, 3'd4, 5'd3};   // Z --..
`ifdef MORSE_DIGITS_EN
            6'd26: dec = {1'b1, 3'd5, 5'd31};  // 0 -----
            6'd27: dec = {1'b1, 3'd5, 5'd30};  // 1 .----
            6'd28: dec = {1'b1, 3'd5, 5'd28};  // 2 ..---
            6'd29: dec = {1'b1, 3'd5, 5'd24};  // 3 ...--
            6'd30: dec = {1'b1, 3'd5, 5'd16};  // 4 ....-
            6'd31: dec = {1'b1, 3'd5, 5'd0};   // 5 .....
            6'd32: dec = {1'b1, 3'd5, 5'd1};   // 6 -....
            6'd33: dec = {1'b1, 3'd5, 5'd3};   // 7 --...
            6'd34: dec = {1'b1, 3'd5, 5'd7};   // 8 ---..
            6'd35: dec = {1'b1, 3'd5, 5'd15};  // 9 ----.
`else
`endif
            default: dec = '0;
        endcase
        return dec;
    endfunction

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [4:0]         pat_q, pat_d;
    logic [2:0]         len_q, len_d;
    logic [2:0]         sym_q, sym_d;
    logic               err_q, err_d;
    logic [8:0]         dec;
    logic [TIMER_W-1:0] mark_last;

    assign dec       = decode(bus.code_in);
    assign mark_last = pat_q[0] ? DashLast : DotLast;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TIMER_W'(1);
        pat_d   = pat_q;
        len_d   = len_q;
        sym_d   = sym_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                timer_d = '0;
                // abort is ignored here, so an accept in the same cycle still wins
                if (bus.code_valid) begin
                    if (dec[8]) begin
                        pat_d   = dec[4:0];
                        len_d   = dec[7:5];
                        sym_d   = '0;
                        state_d = StMark;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StMark: begin
                if (bus.abort) begin
                    state_d = StLgap;
                    timer_d = '0;
                end else if (timer_q == mark_last) begin
                    timer_d = '0;
                    if (sym_q == len_q - 3'd1) begin
                        state_d = StLgap;
                    end else begin
                        state_d = StSpace;
                        pat_d   = pat_q >> 1;
                    end
                end
            end
            StSpace: begin
                if (bus.abort) begin
                    state_d = StLgap;
                    timer_d = '0;
                end else if (timer_q == DotLast) begin
                    state_d = StMark;
                    timer_d = '0;
                    sym_d   = sym_q + 3'd1;
                end
            end
            StLgap: begin
                if (timer_q == GapLast) begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            timer_q <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            sym_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            sym_q   <= sym_d;
            err_q   <= err_d;
        end
    end

    assign bus.light      = (state_q == StMark);
    assign bus.busy       = (state_q != StIdle);
    assign bus.code_ready = (state_q == StIdle);
    assign bus.err        = err_q;

endmodule
